// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: byte FIFO feeding 11-bit device-to-host frames.
// Optional host-inhibit detection/abort is built when PS2_TX_INHIBIT_EN is defined.
module ps2_dev_tx #(
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic                          ps2_clk_i,
    output logic                          ps2_clk_o,
    output logic                          ps2_dat_o,
    output logic                          busy_o,
    output logic                          frame_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

    state_t          state;
    logic [TW-1:0]   tmr;
    logic [3:0]      idx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   cnt_nxt;
    logic [7:0]      head;
    logic [10:0]     frame;
    logic            wr_en, pop, tmr_done, inhibit, abort;

    assign wr_en    = wr_valid_i && wr_ready_o;
    assign tmr_done = (tmr == TW'(CLK_DIV - 1));
    assign pop      = (state == BIT_LO) && tmr_done && (idx == 4'd10);
    assign head     = mem[rd_ptr];
    assign frame    = {1'b1, ~^head, head, 1'b0};

`ifdef PS2_TX_INHIBIT_EN
    logic [1:0] clk_sync;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) clk_sync <= 2'b11;
        else       clk_sync <= {clk_sync[0], ps2_clk_i};
    end
    // Only meaningful while we release the clock line; we cannot see the host through our own low.
    assign inhibit = !clk_sync[1] && ps2_clk_o;
`else
    logic unused_ps2_clk;
    assign unused_ps2_clk = ps2_clk_i;
    assign inhibit = 1'b0;
`endif

    assign abort = inhibit && (state == BIT_HI) && (tmr >= TW'(2)) && (idx <= 4'd9);

    always_comb begin
        cnt_nxt = fifo_level_o;
        case ({wr_en, pop})
            2'b10:   cnt_nxt = fifo_level_o + LW'(1);
            2'b01:   cnt_nxt = fifo_level_o - LW'(1);
            default: cnt_nxt = fifo_level_o;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            wr_ready_o   <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            fifo_level_o <= cnt_nxt;
            wr_ready_o   <= (cnt_nxt != LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            tmr          <= '0;
            idx          <= '0;
            ps2_clk_o    <= 1'b1;
            ps2_dat_o    <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_level_o != '0 && !inhibit) begin
                        state     <= BIT_HI;
                        idx       <= '0;
                        tmr       <= '0;
                        ps2_dat_o <= frame[0];
                        busy_o    <= 1'b1;
                    end
                end
                BIT_HI: begin
                    if (abort) begin
                        // Frame restarts from the start bit once the host releases the line.
                        state     <= IDLE;
                        tmr       <= '0;
                        ps2_clk_o <= 1'b1;
                        ps2_dat_o <= 1'b1;
                        busy_o    <= 1'b0;
                    end else if (tmr_done) begin
                        state     <= BIT_LO;
                        tmr       <= '0;
                        ps2_clk_o <= 1'b0;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                BIT_LO: begin
                    if (tmr_done) begin
                        tmr       <= '0;
                        ps2_clk_o <= 1'b1;
                        if (idx < 4'd10) begin
                            state     <= BIT_HI;
                            idx       <= idx + 4'd1;
                            ps2_dat_o <= frame[idx + 4'd1];
                        end else begin
                            state        <= GAP;
                            ps2_dat_o    <= 1'b1;
                            frame_done_o <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                GAP: begin
                    if (tmr_done) begin
                        state  <= IDLE;
                        tmr    <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_dev_tx.sv
// Directed bench for ps2_dev_tx with CLK_DIV=4, FIFO_DEPTH=4 and a loopback frame receiver.
module tb_ps2_dev_tx;
    localparam int D = 4;
    localparam int DEPTH = 4;

    logic       clk = 0, rst = 1;
    logic [7:0] wr_data = 0;
    logic       wr_valid = 0, ps2_clk_in = 1;
    logic       wr_ready, ps2_clk, ps2_dat, busy, frame_done;
    logic [2:0] level;

    int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
    int done_q[$];
    logic [10:0] rx_q[$];
    logic [10:0] rx_bits;
    int rx_n = 0;
    logic prev_sclk = 1;

    ps2_dev_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready), .ps2_clk_i(ps2_clk_in), .ps2_clk_o(ps2_clk),
        .ps2_dat_o(ps2_dat), .busy_o(busy), .frame_done_o(frame_done), .fifo_level_o(level));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Loopback receiver: samples data on falling PS/2 clock, resyncs whenever the sender is idle.
    always @(negedge clk) begin
        if (frame_done) begin done_cnt++; done_q.push_back(cyc); end
        if (!busy || rst) rx_n = 0;
        else if (prev_sclk && !ps2_clk) begin
            rx_bits[rx_n] = ps2_dat;
            rx_n++;
            if (rx_n == 11) begin rx_q.push_back(rx_bits); rx_n = 0; end
        end
        prev_sclk = ps2_clk;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write1(input logic [7:0] b);
        wr_data = b; wr_valid = 1;
        @(posedge clk); #1;
        wr_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while ((busy || level != 0) && w < budget) begin step(1); w++; end
        checks++;
        if (busy || level != 0) begin
            errors++; $display("FAIL wait_idle timeout busy=%0b level=%0d", busy, level);
        end
    endtask

    task automatic test_reset;
        rst = 1; step(2);
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL rst_clk got %b exp 1", ps2_clk); end
        checks++; if (ps2_dat !== 1'b1) begin errors++; $display("FAIL rst_dat got %b exp 1", ps2_dat); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        rst = 0; step(2);
    endtask

    task automatic test_frame_1c;
        int n0, d0, first_fall = -1;
        rx_q.delete(); d0 = done_cnt;
        write1(8'h1C); n0 = cyc;
        checks++; if (ps2_dat !== 1'b1) begin errors++; $display("FAIL pre_start dat got %b exp 1", ps2_dat); end
        step(1);
        checks++; if (ps2_dat !== 1'b0 || ps2_clk !== 1'b1) begin
            errors++; $display("FAIL start_bit clk/dat got %b%b exp 10", ps2_clk, ps2_dat); end
        for (int c = 0; c < 200 && busy; c++) begin
            step(1);
            if (first_fall < 0 && !ps2_clk) first_fall = cyc - n0;
        end
        checks++; if (first_fall != 5) begin errors++; $display("FAIL first_fall got %0d exp 5", first_fall); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_count got %0d exp 1", done_cnt - d0); end
        else begin
            checks++; if (done_q[d0] - n0 != 89) begin
                errors++; $display("FAIL done_cycle got %0d exp 89", done_q[d0] - n0); end
            checks++; if (done_q[d0] - (n0 + 1) != 88) begin
                errors++; $display("FAIL done_after_start got %0d exp 88", done_q[d0] - (n0 + 1)); end
        end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 11'b10000111000) begin
            errors++; $display("FAIL frame_1c got n=%0d %b exp 10000111000", rx_q.size(),
                               rx_q.size() > 0 ? rx_q[0] : 11'h0); end
    endtask

    task automatic test_two_frames;
        int d0, ndone = 0, hi_run = 0;
        bit gap_seen = 0;
        wait_idle(500);
        rx_q.delete(); d0 = done_cnt;
        wr_data = 8'hFF; wr_valid = 1; step(1);
        wr_data = 8'h00; step(1); wr_valid = 0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL level_two got %0d exp 2", level); end
        for (int c = 0; c < 400 && !(ndone == 2 && !busy); c++) begin
            step(1);
            if (ndone == 1 && !gap_seen) begin
                if (ps2_clk && ps2_dat) hi_run++;
                else begin
                    gap_seen = 1;
                    checks++; if (hi_run != 5) begin errors++; $display("FAIL gap_len got %0d exp 5", hi_run); end
                end
            end
            if (frame_done) begin
                ndone++;
                if (ndone == 1) begin
                    hi_run = (ps2_clk && ps2_dat) ? 1 : 0;
                    checks++; if (level !== 3'd1) begin errors++; $display("FAIL level_mid got %0d exp 1", level); end
                end else begin
                    checks++; if (level !== 3'd0) begin errors++; $display("FAIL level_end got %0d exp 0", level); end
                end
            end
        end
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL two_count got %0d exp 2", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 11'b11111111110) begin errors++; $display("FAIL frame_ff got %b exp 11111111110", rx_q[0]); end
            checks++; if (rx_q[1] !== 11'b11000000000) begin errors++; $display("FAIL frame_00 got %b exp 11000000000", rx_q[1]); end
            checks++; if (rx_q[0][9] !== 1'b1 || rx_q[1][9] !== 1'b1) begin
                errors++; $display("FAIL parity_ff_00 got %b%b exp 11", rx_q[0][9], rx_q[1][9]); end
        end
    endtask

    task automatic test_fill;
        logic [7:0] b [5] = '{8'h11, 8'h22, 8'h37, 8'h4C, 8'hE5};
        int acc [5];
        int d0, w;
        wait_idle(500);
        rx_q.delete(); d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            wr_data = b[i]; wr_valid = 1; w = 0;
            while (!wr_ready && w < 500) begin step(1); w++; end
            step(1); acc[i] = cyc;
            if (i == 3) begin
                checks++; if (wr_ready !== 1'b0 || level !== 3'd4) begin
                    errors++; $display("FAIL full got ready=%b level=%0d exp ready=0 level=4", wr_ready, level); end
            end
        end
        wr_valid = 0;
        checks++; if (acc[3] - acc[0] != 3) begin errors++; $display("FAIL fill_b2b got %0d exp 3", acc[3] - acc[0]); end
        checks++; if (done_q.size() <= d0 || acc[4] != done_q[d0] + 1) begin
            errors++; $display("FAIL fifth_accept got %0d exp first_done+1", acc[4]); end
        wait_idle(1500);
        checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL fill_count got %0d exp 5", rx_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q[i][8:1] !== b[i] || rx_q[i][0] !== 1'b0 || rx_q[i][10] !== 1'b1 || rx_q[i][9] !== ~^b[i]) begin
                errors++; $display("FAIL fill_frame%0d got %b data exp %h", i, rx_q[i], b[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        bit started = 0;
        wait_idle(500);
        wr_data = 8'h12; wr_valid = 1; step(1); n0 = cyc;
        wr_data = 8'h34; step(1);
        wr_data = 8'h56; step(1); wr_valid = 0;
        while (cyc < n0 + 43) step(1);
        checks++; if (level !== 3'd3 || !busy) begin
            errors++; $display("FAIL pre_reset got level=%0d busy=%b exp 3 1", level, busy); end
        rst = 1; #2;
        checks++; if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            errors++; $display("FAIL mid_rst_lines got %b%b exp 11", ps2_clk, ps2_dat); end
        checks++; if (level !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL mid_rst_state got level=%0d busy=%b ready=%b", level, busy, wr_ready); end
        step(2); rst = 0;
        for (int c = 0; c < 300; c++) begin
            step(1);
            if (busy || !ps2_dat || !ps2_clk) started = 1;
        end
        checks++; if (started) begin errors++; $display("FAIL post_rst_start got 1 exp 0"); end
    endtask

`ifdef PS2_TX_INHIBIT_EN
    task automatic test_inhibit;
        int n0, d0;
        wait_idle(500);
        rx_q.delete(); d0 = done_cnt;
        write1(8'h5A); n0 = cyc;
        while (cyc < n0 + 25) step(1);
        ps2_clk_in = 0;
        step(3);
        checks++; if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort got clk=%b dat=%b busy=%b exp 1 1 0", ps2_clk, ps2_dat, busy); end
        step(47);
        checks++; if (busy !== 1'b0 || done_cnt != d0 || level !== 3'd1) begin
            errors++; $display("FAIL held_off got busy=%b done=%0d level=%0d", busy, done_cnt - d0, level); end
        ps2_clk_in = 1;
        wait_idle(500);
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL inh_done got %0d exp 1", done_cnt - d0); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 11'b11010110100) begin
            errors++; $display("FAIL inh_frame got n=%0d %b exp 11010110100", rx_q.size(),
                               rx_q.size() > 0 ? rx_q[0] : 11'h0); end
    endtask
`else
    task automatic test_no_inhibit;
        int d0;
        wait_idle(500);
        rx_q.delete(); d0 = done_cnt;
        ps2_clk_in = 0;
        write1(8'hA5);
        step(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noinh_start got busy=%b exp 1", busy); end
        wait_idle(500);
        ps2_clk_in = 1;
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL noinh_done got %0d exp 1", done_cnt - d0); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 11'b11101001010) begin
            errors++; $display("FAIL noinh_frame got n=%0d %b exp 11101001010", rx_q.size(),
                               rx_q.size() > 0 ? rx_q[0] : 11'h0); end
    endtask
`endif

    initial begin
        test_reset;
        test_frame_1c;
        test_two_frames;
        test_fill;
`ifdef PS2_TX_INHIBIT_EN
        test_inhibit;
`else
        test_no_inhibit;
`endif
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
